// File: rtl/scsi_io_arbiter_pkg.sv
// Shared types and sizes for the SCSI target / host block-channel arbiter.
package scsi_pkg;

  localparam int SCSI_LBA_W = 32;
  localparam int SCSI_NTGT  = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_XFER,
    ARB_DONE
  } arb_state_t;

endpackage

// File: rtl/scsi_io_arbiter_if.sv
// Host SD/io-controller block channel as seen by the arbiter.
// The master side is the arbiter and the slave side is the host controller.
interface scsi_io_arbiter_if;
  import scsi_pkg::*;

  logic [SCSI_LBA_W-1:0] sd_lba;
  logic                  sd_rd;
  logic                  sd_wr;
  logic                  sd_dev;
  logic                  sd_ack;
  logic                  sd_buff_wr;
  logic [7:0]            sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_dev, sd_buff_din,
    input  sd_ack, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_dev, sd_buff_din,
    output sd_ack, sd_buff_wr
  );

endinterface

// File: rtl/scsi_io_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
// When both inputs are pending, the one that was not served last wins.
module rr_arb2 (
  input  logic [1:0] i_pending,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_idx
);

  assign o_valid = |i_pending;
  assign o_idx   = (&i_pending) ? ~i_last : i_pending[1];

endmodule

// File: rtl/scsi_io_arbiter.sv
// Shares one host block channel between two SCSI targets.
// A request is granted round-robin and held until the host drops sd_ack.
// A watchdog aborts a request that the host never acknowledges.
module scsi_io_arbiter
  import scsi_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SCSI_LBA_W-1:0] t_lba0,
  input  logic [SCSI_LBA_W-1:0] t_lba1,
  input  logic [SCSI_NTGT-1:0]  t_rd,
  input  logic [SCSI_NTGT-1:0]  t_wr,
  output logic [SCSI_NTGT-1:0]  t_ack,
  input  logic [7:0]            t_buff_din0,
  input  logic [7:0]            t_buff_din1,
  output logic [SCSI_NTGT-1:0]  t_buff_wr,
  scsi_io_arbiter_if.master     host,
  output logic                  err
);

  localparam logic [31:0] TO_LAST = TIMEOUT - 32'd1;

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic                  r_gnt;
  logic                  r_last;
  logic                  r_sd_rd;
  logic                  r_sd_wr;
  logic                  r_to_pulse;
  logic                  r_err;
  logic [SCSI_LBA_W-1:0] r_lba;
  logic [31:0]           r_wdog;

  logic [SCSI_NTGT-1:0]  w_pending;
  logic                  w_arb_vld;
  logic                  w_arb_idx;
  logic                  w_load;
  logic                  w_timeout;
  logic                  w_wd_hit;
  logic                  w_busy;
  logic [SCSI_NTGT-1:0]  w_sel;

  assign w_pending = t_rd | t_wr;

  rr_arb2 u_rr_arb2 (
    .i_pending (w_pending),
    .i_last    (r_last),
    .o_valid   (w_arb_vld),
    .o_idx     (w_arb_idx)
  );

  // A zero TIMEOUT disables the watchdog entirely.
  assign w_wd_hit = (TIMEOUT != 32'd0) && (r_wdog >= TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic plus grant-load and abort strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_arb_vld) begin
          w_state_nxt = ARB_REQ;
          w_load      = 1'b1;
        end
      end
      ARB_REQ: begin
        if (host.sd_ack) begin
          w_state_nxt = ARB_XFER;
        end else if (w_wd_hit) begin
          w_state_nxt = ARB_DONE;
          w_timeout   = 1'b1;
        end
      end
      ARB_XFER: begin
        if (!host.sd_ack) w_state_nxt = ARB_DONE;
      end
      ARB_DONE: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Grant, LBA and host request lines; write wins when a target shows both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= 1'b0;
      r_lba   <= '0;
      r_sd_rd <= 1'b0;
      r_sd_wr <= 1'b0;
    end else if (w_load) begin
      r_gnt   <= w_arb_idx;
      r_lba   <= w_arb_idx ? t_lba1 : t_lba0;
      r_sd_wr <= t_wr[w_arb_idx];
      r_sd_rd <= ~t_wr[w_arb_idx];
    end else if ((r_state == ARB_REQ) && (w_state_nxt != ARB_REQ)) begin
      r_sd_rd <= 1'b0;
      r_sd_wr <= 1'b0;
    end
  end

  // Watchdog: cleared on entry to REQ, counts while waiting, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (w_load) begin
      r_wdog <= '0;
    end else if ((r_state == ARB_REQ) && (r_wdog != 32'hFFFF_FFFF)) begin
      r_wdog <= r_wdog + 32'd1;
    end
  end

  // Abort pulse, sticky error flag and last-served pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_pulse <= 1'b0;
      r_err      <= 1'b0;
      r_last     <= 1'b1;
    end else begin
      r_to_pulse <= w_timeout;
      if (w_timeout)            r_err  <= 1'b1;
      if (r_state == ARB_DONE)  r_last <= r_gnt;
    end
  end

  // Ack and buffer strobes reach only the granted target; gnt is stable
  // from REQ through DONE so these and the read mux never glitch mid-sector.
  assign w_busy    = (r_state == ARB_REQ) || (r_state == ARB_XFER);
  assign w_sel     = {r_gnt, ~r_gnt};
  assign t_ack     = w_sel & {SCSI_NTGT{(host.sd_ack & w_busy) | r_to_pulse}};
  assign t_buff_wr = w_sel & {SCSI_NTGT{host.sd_buff_wr & (r_state == ARB_XFER)}};

  assign host.sd_lba      = r_lba;
  assign host.sd_rd       = r_sd_rd;
  assign host.sd_wr       = r_sd_wr;
  assign host.sd_dev      = r_gnt;
  assign host.sd_buff_din = r_gnt ? t_buff_din1 : t_buff_din0;
  assign err              = r_err;

endmodule

// File: tb/tb_scsi_io_arbiter.sv
// Self-checking bench for scsi_io_arbiter: directed host/target scenarios,
// with expected host requests queued and checked by a separate monitor.
module tb_scsi_io_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] t_lba0 = '0;
  logic [31:0] t_lba1 = '0;
  logic [1:0]  t_rd = '0;
  logic [1:0]  t_wr = '0;
  logic [1:0]  t_ack;
  logic [7:0]  t_buff_din0 = 8'h3C;
  logic [7:0]  t_buff_din1 = 8'hC3;
  logic [1:0]  t_buff_wr;
  logic        err;

  scsi_io_arbiter_if host_if ();

  scsi_io_arbiter #(.TIMEOUT(32'd16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .t_lba0      (t_lba0),
    .t_lba1      (t_lba1),
    .t_rd        (t_rd),
    .t_wr        (t_wr),
    .t_ack       (t_ack),
    .t_buff_din0 (t_buff_din0),
    .t_buff_din1 (t_buff_din1),
    .t_buff_wr   (t_buff_wr),
    .host        (host_if),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        dev;
    logic [31:0] lba;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_req(input logic wr, input logic dev, input logic [31:0] lba);
    exp_t e;
    e.rd  = ~wr;
    e.wr  = wr;
    e.dev = dev;
    e.lba = lba;
    q.push_back(e);
  endtask

  // Monitor: each new host request is checked against the next queued entry.
  initial begin : monitor
    logic prev_req;
    logic cur_req;
    exp_t e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      cur_req = host_if.sd_rd | host_if.sd_wr;
      if (cur_req && !prev_req) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got rd=%0b wr=%0b dev=%0b lba=0x%0h expected none",
                   host_if.sd_rd, host_if.sd_wr, host_if.sd_dev, host_if.sd_lba);
        end else begin
          e = q.pop_front();
          chk("req_rd",  64'(host_if.sd_rd),  64'(e.rd));
          chk("req_wr",  64'(host_if.sd_wr),  64'(e.wr));
          chk("req_dev", 64'(host_if.sd_dev), 64'(e.dev));
          chk("req_lba", 64'(host_if.sd_lba), 64'(e.lba));
        end
      end
      prev_req = cur_req;
    end
  end

  // Bounded wait for a host request; returns at the negedge it is seen.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (host_if.sd_rd || host_if.sd_wr) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_req_timeout", 64'd0, 64'd1);
  endtask

  // Host acks the pending request, issues nstb buffer strobes, then releases.
  task automatic serve(input int dev, input int nstb);
    bit         ok;
    int         c0;
    int         c1;
    int         bad;
    logic [1:0] sel;
    sel = (dev == 0) ? 2'b01 : 2'b10;
    c0  = 0;
    c1  = 0;
    bad = 0;
    wait_req(ok);
    if (!ok) return;
    @(posedge clk);
    #1;
    host_if.sd_ack = 1'b1;
    t_rd[dev] = 1'b0;
    t_wr[dev] = 1'b0;
    #1;
    chk("ack_in_req", 64'(t_ack), 64'(sel));
    @(posedge clk);
    @(negedge clk);
    chk("req_drop", 64'({host_if.sd_rd, host_if.sd_wr}), 64'd0);
    for (int i = 0; i < nstb; i++) begin
      @(posedge clk);
      #1;
      host_if.sd_buff_wr = 1'b1;
      @(negedge clk);
      c0 += int'(t_buff_wr[0]);
      c1 += int'(t_buff_wr[1]);
      if (t_ack !== sel) bad++;
    end
    @(posedge clk);
    #1;
    host_if.sd_buff_wr = 1'b0;
    host_if.sd_ack     = 1'b0;
    #1;
    chk("ack_release", 64'(t_ack), 64'd0);
    chk("ack_mirror_errs", 64'(bad), 64'd0);
    chk("buff_wr0_cnt", 64'(c0), (dev == 0) ? 64'(nstb) : 64'd0);
    chk("buff_wr1_cnt", 64'(c1), (dev == 1) ? 64'(nstb) : 64'd0);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    bit ok;
    int hi;
    int p0;
    int p1;
    host_if.sd_ack     = 1'b0;
    host_if.sd_buff_wr = 1'b0;

    // Reset values.
    #3;
    chk("rst_sd_rd",     64'(host_if.sd_rd),  64'd0);
    chk("rst_sd_wr",     64'(host_if.sd_wr),  64'd0);
    chk("rst_sd_dev",    64'(host_if.sd_dev), 64'd0);
    chk("rst_sd_lba",    64'(host_if.sd_lba), 64'd0);
    chk("rst_t_ack",     64'(t_ack),          64'd0);
    chk("rst_t_buff_wr", 64'(t_buff_wr),      64'd0);
    chk("rst_err",       64'(err),            64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Spurious ack and strobe in IDLE never reach a target.
    @(posedge clk);
    #1;
    host_if.sd_ack     = 1'b1;
    host_if.sd_buff_wr = 1'b1;
    p0 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (t_ack !== 2'b00 || t_buff_wr !== 2'b00 || host_if.sd_rd || host_if.sd_wr) p0++;
    end
    chk("spurious_ack", 64'(p0), 64'd0);
    @(posedge clk);
    #1;
    host_if.sd_ack     = 1'b0;
    host_if.sd_buff_wr = 1'b0;

    // Single read from target 0, full sector.
    t_lba0 = 32'h100;
    expect_req(1'b0, 1'b0, 32'h100);
    t_rd[0] = 1'b1;
    serve(0, 512);

    // Simultaneous requests after reset: target 0 write first, then target 1 read.
    repeat (3) @(posedge clk);
    do_reset();
    t_lba0 = 32'd9;
    t_lba1 = 32'd7;
    expect_req(1'b1, 1'b0, 32'd9);
    expect_req(1'b0, 1'b1, 32'd7);
    t_rd[1] = 1'b1;
    t_wr[0] = 1'b1;
    serve(0, 4);
    serve(1, 4);

    // Fairness: target 0 keeps re-requesting while target 1 is pending.
    repeat (3) @(posedge clk);
    t_lba0 = 32'h20;
    t_lba1 = 32'h21;
    expect_req(1'b0, 1'b0, 32'h20);
    expect_req(1'b0, 1'b1, 32'h21);
    expect_req(1'b0, 1'b0, 32'h20);
    expect_req(1'b0, 1'b1, 32'h21);
    t_rd = 2'b11;
    for (int k = 0; k < 4; k++) begin
      serve(k % 2, 2);
      if (k < 2) t_rd[k % 2] = 1'b1;
    end

    // Watchdog: host never acks.
    repeat (3) @(posedge clk);
    t_lba0 = 32'h55;
    expect_req(1'b0, 1'b0, 32'h55);
    t_rd[0] = 1'b1;
    wait_req(ok);
    hi = ok ? 1 : 0;
    p0 = 0;
    p1 = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (host_if.sd_rd) hi++;
      if (t_ack[0]) begin
        p0++;
        t_rd[0] = 1'b0;
      end
      if (t_ack[1]) p1++;
    end
    t_rd[0] = 1'b0;
    chk("wd_req_cycles", 64'(hi),  64'd16);
    chk("wd_ack0_pulse", 64'(p0),  64'd1);
    chk("wd_ack1_pulse", 64'(p1),  64'd0);
    chk("wd_err",        64'(err), 64'd1);
    chk("wd_idle_rd",    64'({host_if.sd_rd, host_if.sd_wr}), 64'd0);

    // Reset in the middle of a transfer, then a normal write from target 1.
    t_lba1 = 32'hAB;
    expect_req(1'b1, 1'b1, 32'hAB);
    t_wr[1] = 1'b1;
    wait_req(ok);
    @(posedge clk);
    #1;
    host_if.sd_ack = 1'b1;
    t_wr[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    host_if.sd_buff_wr = 1'b1;
    #2;
    chk("xfer_buff_wr1", 64'(t_buff_wr), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sd_rd_wr", 64'({host_if.sd_rd, host_if.sd_wr}), 64'd0);
    chk("mid_rst_sd_dev",   64'(host_if.sd_dev), 64'd0);
    chk("mid_rst_sd_lba",   64'(host_if.sd_lba), 64'd0);
    chk("mid_rst_t_ack",    64'(t_ack),          64'd0);
    chk("mid_rst_buff_wr",  64'(t_buff_wr),      64'd0);
    chk("mid_rst_err",      64'(err),            64'd0);
    host_if.sd_ack     = 1'b0;
    host_if.sd_buff_wr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t_lba1 = 32'hCD;
    expect_req(1'b1, 1'b1, 32'hCD);
    t_wr[1] = 1'b1;
    serve(1, 3);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
